lc3_mem_ctrl: RTL and testbench

//  CPU-side initiator for the LC-3 word memory and memory-mapped I/O.

---
 rtl/lc3_mem_ctrl_if.sv | 15 +
 rtl/lc3_mem_ctrl.sv | 150 +++++++++++++++
 tb/tb_lc3_mem_ctrl.sv | 292 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lc3_mem_ctrl_if.sv
// Word-memory bus between the LC-3 memory controller (master) and the RAM block (slave).
// The same address drives both the read and the write port of the memory.
interface lc3_mem_ctrl_if #(
   parameter int ADDR_W = 7
);
   logic              we;
   logic              re;
   logic [ADDR_W-1:0] addr;
   logic [15:0]       wdata;
   logic [15:0]       rdata;
   logic              ready;

   modport master (output we, re, addr, wdata, input rdata, ready);
   modport slave  (input we, re, addr, wdata, output rdata, ready);
endinterface

// File: rtl/lc3_mem_ctrl.sv
// LC-3 MAR/MDR access initiator: routes one request to RAM (strobe/ready handshake),
// serves the keyboard/display registers locally, flags illegal addresses and pulses r.
module lc3_mem_ctrl #(
   parameter int ADDR_W  = 7,
   parameter int TIMEOUT = 15
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           req,
   input  logic           rw,
   input  logic [15:0]    mar,
   input  logic [15:0]    mdr_in,
   output logic [15:0]    mdr_out,
   output logic           r,
   output logic           acv,
   output logic           mem_err,
   lc3_mem_ctrl_if.master mem,
   input  logic           kb_valid,
   input  logic [7:0]     kb_data,
   input  logic           dsp_ready,
   output logic           dsp_valid,
   output logic [7:0]     dsp_data
);
   localparam logic [15:0] KBSR_ADDR = 16'hFE00;
   localparam logic [15:0] KBDR_ADDR = 16'hFE02;
   localparam logic [15:0] DSR_ADDR  = 16'hFE04;
   localparam logic [15:0] DDR_ADDR  = 16'hFE06;
   localparam logic [3:0]  WAIT_LAST = 4'(TIMEOUT - 1);

   typedef enum logic [2:0] {IDLE, WR, RD, DRAIN, DONE} state_t;

   state_t            state, state_d;
   logic [3:0]        wait_cnt;
   logic [ADDR_W-1:0] addr_q;
   logic [15:0]       mdr_q;
   logic              we_q, re_q;
   logic              kbsr;
   logic [7:0]        kbdr;
   logic              acv_d, err_d;
   logic              is_ram, is_io, accept, kbdr_read, dsp_fire, timed_out;
   logic [15:0]       io_rdata;

   assign is_ram    = (mar[15:ADDR_W] == '0);
   assign is_io     = (mar == KBSR_ADDR) || (mar == KBDR_ADDR) ||
                      (mar == DSR_ADDR)  || (mar == DDR_ADDR);
   assign accept    = (state == IDLE) && req;
   assign kbdr_read = accept && !rw && (mar == KBDR_ADDR);
   assign dsp_fire  = accept && rw && (mar == DDR_ADDR) && dsp_ready;
   // Counter holds TIMEOUT-1 on the last waiting cycle, so the abort edge is where it reaches TIMEOUT.
   assign timed_out = (wait_cnt == WAIT_LAST);

   // NOTE: every signal written in an always_comb gets a default first, so no latch is inferred.
   always_comb begin
      io_rdata = '0;
      case (mar)
         KBSR_ADDR: io_rdata = {kbsr, 15'b0};
         KBDR_ADDR: io_rdata = {8'b0, kbdr};
         DSR_ADDR:  io_rdata = {dsp_ready, 15'b0};
         default:   io_rdata = '0;
      endcase
   end

   always_comb begin
      state_d = state;
      acv_d   = 1'b0;
      err_d   = 1'b0;
      case (state)
         IDLE: if (req) begin
            if (is_ram) begin
               state_d = rw ? WR : RD;
            end else begin
               state_d = DONE;
               acv_d   = !is_io;
            end
         end
         WR, RD: if (mem.ready) begin
            state_d = DRAIN;
         end else if (timed_out) begin
            state_d = DONE;
            err_d   = 1'b1;
         end
         // Waiting for ready to fall keeps a stale ready from completing the next access.
         DRAIN: if (!mem.ready) begin
            state_d = DONE;
         end else if (timed_out) begin
            state_d = DONE;
            err_d   = 1'b1;
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         wait_cnt <= '0;
      end else begin
         state <= state_d;
         if (state_d != state)     wait_cnt <= '0;
         else if (wait_cnt != 4'hF) wait_cnt <= wait_cnt + 4'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r         <= 1'b0;
         acv       <= 1'b0;
         mem_err   <= 1'b0;
         we_q      <= 1'b0;
         re_q      <= 1'b0;
         addr_q    <= '0;
         mdr_q     <= '0;
         mdr_out   <= '0;
         kbsr      <= 1'b0;
         kbdr      <= '0;
         dsp_valid <= 1'b0;
         dsp_data  <= '0;
      end else begin
         r         <= (state_d == DONE);
         acv       <= acv_d;
         mem_err   <= err_d;
         we_q      <= (state_d == WR);
         re_q      <= (state_d == RD);
         dsp_valid <= dsp_fire;
         if (accept) begin
            addr_q <= mar[ADDR_W-1:0];
            mdr_q  <= mdr_in;
         end
         if (dsp_fire) dsp_data <= mdr_in[7:0];
         if (accept && !rw && is_io)          mdr_out <= io_rdata;
         else if ((state == RD) && mem.ready) mdr_out <= mem.rdata;
         // A keystroke landing on a KBDR read still loads: the reader gets the old character.
         if (kb_valid && (!kbsr || kbdr_read)) begin
            kbdr <= kb_data;
            kbsr <= 1'b1;
         end else if (kbdr_read) begin
            kbsr <= 1'b0;
         end
      end
   end

   assign mem.we    = we_q;
   assign mem.re    = re_q;
   assign mem.addr  = addr_q;
   // Outside a write the memory sees its own read data, so any stray write preserves contents.
   assign mem.wdata = (state == WR) ? mdr_q : mem.rdata;

endmodule

// File: tb/tb_lc3_mem_ctrl.sv
// Self-checking bench for lc3_mem_ctrl: transaction-level reference model, a latency-parameterised
// RAM responder, directed literal scenarios and a randomized access mix.
`timescale 1ns/1ps
module tb_lc3_mem_ctrl;
   localparam int ADDR_W = 7;
   localparam int NEVER  = 0;
   localparam int BIG    = 1 << 30;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req = 1'b0, rw = 1'b0;
   logic [15:0] mar = '0, mdr_in = '0;
   logic [15:0] mdr_out;
   logic        r, acv, mem_err;
   logic        kb_valid = 1'b0;
   logic [7:0]  kb_data = '0;
   logic        dsp_ready = 1'b0;
   logic        dsp_valid;
   logic [7:0]  dsp_data;

   lc3_mem_ctrl_if #(.ADDR_W(ADDR_W)) mem ();

   lc3_mem_ctrl #(.ADDR_W(ADDR_W), .TIMEOUT(15)) dut (
      .clk(clk), .rst_n(rst_n), .req(req), .rw(rw), .mar(mar), .mdr_in(mdr_in),
      .mdr_out(mdr_out), .r(r), .acv(acv), .mem_err(mem_err), .mem(mem),
      .kb_valid(kb_valid), .kb_data(kb_data), .dsp_ready(dsp_ready),
      .dsp_valid(dsp_valid), .dsp_data(dsp_data)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [15:0] init_word(input int i);
      return 16'(i * 257) ^ 16'h5A5A;
   endfunction

   // Absolute edge counter; cycle k of an access is the interval after edge t0+k.
   int tcyc = 0;
   always @(posedge clk) tcyc <= tcyc + 1;

   // RAM responder: ready rises once the strobe has been seen high mem_delay times,
   // and falls on the edge after the strobe is seen low.
   logic [15:0] mem_arr [128];
   bit          mem_loaded;
   int          mem_delay = 2;
   int          hi_cnt;
   always @(posedge clk) begin
      if (!mem_loaded) begin
         for (int i = 0; i < 128; i++) mem_arr[i] <= init_word(i);
         mem_loaded <= 1'b1;
      end else if (mem.we) begin
         mem_arr[mem.addr] <= mem.wdata;
      end
      mem.rdata <= mem_arr[mem.addr];
      if (mem.we || mem.re) begin
         hi_cnt    <= hi_cnt + 1;
         mem.ready <= (mem_delay != NEVER) && (hi_cnt + 1 >= mem_delay);
      end else begin
         hi_cnt    <= 0;
         mem.ready <= 1'b0;
      end
   end

   // Reference model state
   typedef struct {
      int          t0;
      int          lat;
      bit          ram;
      bit          rw;
      logic [6:0]  addr;
      logic [15:0] wdata;
      int          sl;
      bit          acv;
      bit          err;
      bit          dsp;
      logic [7:0]  dsp_data;
      logic [15:0] mdr_before;
      logic [15:0] mdr_after;
      int          load_k;
   } exp_t;

   exp_t        ex;
   bit          chk_en = 1'b0;
   logic [15:0] ref_mem [128];
   logic [15:0] m_mdr = '0;
   bit          kbsr_m = 1'b0;
   logic [7:0]  kbdr_m = '0;

   task automatic idle_exp();
      exp_t e;
      e.t0 = tcyc; e.lat = -1; e.ram = 0; e.rw = 0; e.addr = '0; e.wdata = '0; e.sl = 0;
      e.acv = 0; e.err = 0; e.dsp = 0; e.dsp_data = '0;
      e.mdr_before = m_mdr; e.mdr_after = m_mdr; e.load_k = BIG;
      ex = e;
   endtask

   // Per-cycle comparison of every output against the current expected transaction
   always @(negedge clk) begin
      int k;
      if (chk_en) begin
         k = tcyc - ex.t0;
         check("r", r, k == ex.lat);
         check("acv", acv, (k == ex.lat) && ex.acv);
         check("mem_err", mem_err, (k == ex.lat) && ex.err);
         check("mem_we", mem.we, ex.ram && ex.rw && k >= 1 && k <= ex.sl);
         check("mem_re", mem.re, ex.ram && !ex.rw && k >= 1 && k <= ex.sl);
         if (mem.we || mem.re) check("mem_addr", mem.addr, ex.addr);
         if (mem.we) check("mem_wdata", mem.wdata, ex.wdata);
         if (mem.re) check("mem_wdata_rd", mem.wdata, mem.rdata);
         check("dsp_valid", dsp_valid, ex.dsp && k == 1);
         if (dsp_valid) check("dsp_data", dsp_data, ex.dsp_data);
         check("mdr_out", mdr_out, (k >= ex.load_k) ? ex.mdr_after : ex.mdr_before);
      end
   end

   // One access: model computes latency/result from the rules, then the request is driven.
   task automatic access(input bit w, input logic [15:0] a, input logic [15:0] d, input int dly,
                         input bit kbv, input logic [7:0] kbd, input bit dr, output int lat);
      exp_t        e;
      logic [15:0] rd;
      bit          ram, io, rd02, got;
      @(posedge clk); #2;
      ram  = (a[15:7] == '0);
      io   = (a == 16'hFE00) || (a == 16'hFE02) || (a == 16'hFE04) || (a == 16'hFE06);
      rd02 = io && !w && (a == 16'hFE02);
      e.t0 = tcyc; e.ram = ram; e.rw = w; e.addr = a[6:0]; e.wdata = d; e.sl = 0;
      e.acv = 0; e.err = 0; e.dsp = 0; e.dsp_data = d[7:0];
      e.mdr_before = m_mdr; e.mdr_after = m_mdr; e.load_k = BIG; e.lat = 1;
      if (ram) begin
         if (dly == NEVER) begin
            e.sl = 15; e.lat = 16; e.err = 1;
         end else begin
            e.sl = dly + 1; e.lat = dly + 4;
            if (!w) begin e.load_k = dly + 2; e.mdr_after = ref_mem[a[6:0]]; end
         end
         if (w) ref_mem[a[6:0]] = d;
      end else if (io) begin
         if (w) begin
            e.dsp = (a == 16'hFE06) && dr;
         end else begin
            case (a)
               16'hFE00: rd = {kbsr_m, 15'b0};
               16'hFE02: rd = {8'b0, kbdr_m};
               16'hFE04: rd = {dr, 15'b0};
               default:  rd = '0;
            endcase
            e.load_k = 1; e.mdr_after = rd;
         end
      end else begin
         e.acv = 1;
      end
      if (kbv && (!kbsr_m || rd02)) begin kbdr_m = kbd; kbsr_m = 1'b1; end
      else if (rd02) kbsr_m = 1'b0;
      m_mdr = e.mdr_after;
      ex = e;
      mem_delay = dly;
      req = 1'b1; rw = w; mar = a; mdr_in = d;
      kb_valid = kbv; kb_data = kbd; dsp_ready = dr;
      lat = -1; got = 1'b0;
      for (int i = 1; i <= 40; i++) begin
         @(posedge clk); #2;
         kb_valid = 1'b0;
         if (r) begin lat = i; got = 1'b1; break; end
      end
      check("r_seen", got, 1'b1);
      req = 1'b0;
   endtask

   // Idle cycles with an optional keystroke on the first one
   task automatic gap(input int n, input bit kbv, input logic [7:0] kbd);
      @(posedge clk); #2;
      kb_valid = kbv; kb_data = kbd;
      if (kbv && !kbsr_m) begin kbdr_m = kbd; kbsr_m = 1'b1; end
      repeat (n + 1) begin @(posedge clk); #2; kb_valid = 1'b0; end
   endtask

   initial begin
      int          lat, dly, g, sel;
      logic [15:0] a, d;
      bit          w;
      for (int i = 0; i < 128; i++) ref_mem[i] = init_word(i);
      idle_exp();
      repeat (3) @(posedge clk);
      #2;
      check("rst_r", r, 1'b0);
      check("rst_we", mem.we, 1'b0);
      check("rst_re", mem.re, 1'b0);
      check("rst_mdr", mdr_out, 16'h0000);
      check("rst_dsp", dsp_valid, 1'b0);
      check("rst_flags", {acv, mem_err}, 2'b00);
      rst_n = 1'b1;
      idle_exp();
      chk_en = 1'b1;

      // Directed scenarios with hand-computed expectations
      access(1, 16'h0005, 16'hBEEF, 2, 0, 8'h00, 0, lat);
      check("wr_lat", lat, 6);
      gap(0, 0, 8'h00);
      check("mem5", mem_arr[5], 16'hBEEF);
      access(0, 16'h0005, 16'h0000, 2, 0, 8'h00, 0, lat);
      check("rd_lat", lat, 6);
      check("rd_data", mdr_out, 16'hBEEF);
      access(1, 16'h0007, 16'h1111, NEVER, 0, 8'h00, 0, lat);
      check("to_lat", lat, 16);
      check("to_err", mem_err, 1'b1);
      check("to_mdr", mdr_out, 16'hBEEF);
      access(0, 16'h0020, 16'h0000, NEVER, 0, 8'h00, 0, lat);
      check("to_rd_mdr", mdr_out, 16'hBEEF);
      access(0, 16'h3000, 16'h0000, 2, 0, 8'h00, 0, lat);
      check("acv_lat", lat, 1);
      check("acv_flag", acv, 1'b1);
      gap(1, 1, 8'h41);
      access(0, 16'hFE00, 16'h0000, 2, 0, 8'h00, 0, lat);
      check("kbsr_full", mdr_out, 16'h8000);
      access(0, 16'hFE02, 16'h0000, 2, 0, 8'h00, 0, lat);
      check("kbdr_A", mdr_out, 16'h0041);
      access(0, 16'hFE00, 16'h0000, 2, 0, 8'h00, 0, lat);
      check("kbsr_empty", mdr_out, 16'h0000);
      access(1, 16'hFE06, 16'h0048, 2, 0, 8'h00, 1, lat);
      check("dsp_lat", lat, 1);
      check("dsp_strobe", dsp_valid, 1'b1);
      check("dsp_char", dsp_data, 8'h48);
      access(1, 16'hFE06, 16'h0049, 2, 0, 8'h00, 0, lat);
      check("dsp_drop", dsp_valid, 1'b0);
      check("dsp_drop_r", r, 1'b1);
      gap(0, 1, 8'h42);
      access(0, 16'hFE02, 16'h0000, 2, 1, 8'h43, 0, lat);
      check("kb_race_old", mdr_out, 16'h0042);
      access(0, 16'hFE00, 16'h0000, 2, 0, 8'h00, 0, lat);
      check("kb_race_full", mdr_out, 16'h8000);
      access(0, 16'hFE02, 16'h0000, 2, 0, 8'h00, 0, lat);
      check("kb_race_new", mdr_out, 16'h0043);

      // Randomized mix
      for (int n = 0; n < 300; n++) begin
         sel = $urandom_range(0, 9);
         if (sel < 6) a = 16'($urandom_range(0, (sel < 3) ? 15 : 127));
         else if (sel < 8) a = 16'hFE00 + 16'(2 * $urandom_range(0, 3));
         else begin
            a = 16'($urandom_range(16'h0080, 16'hFFFF));
            if (a == 16'hFE00 || a == 16'hFE02 || a == 16'hFE04 || a == 16'hFE06) a[0] = 1'b1;
         end
         dly = $urandom_range(0, 15);
         dly = (dly == 0) ? NEVER : 1 + (dly % 5);
         w = 1'($urandom_range(0, 1));
         d = 16'($urandom);
         access(w, a, d, dly, $urandom_range(0, 3) == 0, 8'($urandom), 1'($urandom_range(0, 1)), lat);
         g = $urandom_range(0, 2);
         if (g > 0) gap(g - 1, $urandom_range(0, 2) == 0, 8'($urandom));
      end

      // Reset in cycle 2 of a write: strobe drops at once, memory keeps the one written word
      chk_en = 1'b0;
      @(posedge clk); #2;
      mem_delay = 2;
      req = 1'b1; rw = 1'b1; mar = 16'h0010; mdr_in = 16'h1234;
      repeat (2) begin @(posedge clk); #2; end
      rst_n = 1'b0;
      #1;
      check("mid_rst_we", mem.we, 1'b0);
      check("mid_rst_r", r, 1'b0);
      check("mid_rst_mdr", mdr_out, 16'h0000);
      req = 1'b0;
      ref_mem[16] = 16'h1234;
      kbsr_m = 1'b0; kbdr_m = '0; m_mdr = '0;
      repeat (2) @(posedge clk);
      #2;
      rst_n = 1'b1;
      idle_exp();
      chk_en = 1'b1;
      access(0, 16'h0010, 16'h0000, 2, 0, 8'h00, 0, lat);
      check("post_rst_lat", lat, 6);
      check("post_rst_data", mdr_out, 16'h1234);
      gap(2, 0, 8'h00);

      for (int i = 0; i < 128; i++) check("mem_final", mem_arr[i], ref_mem[i]);

      chk_en = 1'b0;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
